// File: rtl/axi_lite_mc_fifo.sv
// Multi-channel AXI4-Lite write-push FIFO: AXI writes push, per-channel rd_en pops, AXI reads return status.
// Optional macro AXI_PEEK_EN enables non-destructive head-word reads in the peek address region.
module axi_lite_mc_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int N_CH       = 4,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                     clk_axi,
  input  logic                     axi_reset,
  input  logic [ADDR_WIDTH-1:0]    awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DATA_WIDTH/8-1:0]  wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDR_WIDTH-1:0]    araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic [N_CH-1:0]          rd_en,
  output logic [N_CH*DATA_WIDTH-1:0] rd_data,
  output logic [N_CH-1:0]          rd_valid,
  output logic [N_CH-1:0]          rd_empty,
  output logic [N_CH-1:0]          rd_full,
  output logic [N_CH-1:0]          irq_full,
  output logic [N_CH-1:0]          irq_empty,
  input  logic [N_CH-1:0]          irq_clear_full,
  input  logic [N_CH-1:0]          irq_clear_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  ready_en_q;
  logic                  aw_held_q;
  logic [IW-1:0]         aw_idx_q;
  logic                  w_held_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  w_strb_ok_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [IW-1:0]         ar_idx;
  logic [DATA_WIDTH-1:0] rd_word_d;
  logic [1:0]            rd_resp_d;
  logic                  push_fire;
  logic                  push_ok;
  logic [N_CH-1:0]       aw_sel, full_now, empty_now, push_ch, pop_ch;
  logic [PW-1:0]         cnt [N_CH];
  logic [3:0]            unused_addr;

  assign unused_addr = {awaddr[1:0], araddr[1:0]};
  assign ar_idx      = araddr[ADDR_WIDTH-1:2];

  assign awready = ready_en_q && !aw_held_q && !bvalid_q;
  assign wready  = ready_en_q && !w_held_q && !bvalid_q;
  assign arready = ready_en_q && !rvalid_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

  // An out-of-range index selects no channel, so it falls through to SLVERR.
  assign push_fire = aw_held_q && w_held_q && !bvalid_q;
  assign push_ok   = push_fire && (|aw_sel) && w_strb_ok_q && !(|(aw_sel & full_now));

`ifdef AXI_PEEK_EN
  logic [DATA_WIDTH-1:0] head [N_CH];
`endif

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q, empty_q, full_q, irq_f_q, irq_e_q;

    assign aw_sel[gi]    = (aw_idx_q == IW'(gi));
    assign cnt[gi]       = wptr_q - rptr_q;
    assign full_now[gi]  = (cnt[gi] == PW'(DEPTH));
    assign empty_now[gi] = (cnt[gi] == '0);
    assign push_ch[gi]   = push_ok && aw_sel[gi];
    assign pop_ch[gi]    = rd_en[gi] && !empty_now[gi];
    assign cnt_d         = cnt[gi] + PW'(push_ch[gi]) - PW'(pop_ch[gi]);

    assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = dout_q;
    assign rd_valid[gi]  = valid_q;
    assign rd_empty[gi]  = empty_q;
    assign rd_full[gi]   = full_q;
    assign irq_full[gi]  = irq_f_q;
    assign irq_empty[gi] = irq_e_q;
`ifdef AXI_PEEK_EN
    assign head[gi] = mem_q[rptr_q[AW-1:0]];
`endif

    always_ff @(posedge clk_axi) begin
      if (push_ch[gi]) mem_q[wptr_q[AW-1:0]] <= w_data_q;
    end

    always_ff @(posedge clk_axi or posedge axi_reset) begin
      if (axi_reset) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        dout_q  <= '0;
        valid_q <= 1'b0;
        empty_q <= 1'b1;
        full_q  <= 1'b0;
        irq_f_q <= 1'b0;
        irq_e_q <= 1'b0;
      end else begin
        if (push_ch[gi]) wptr_q <= wptr_q + PW'(1);
        if (pop_ch[gi]) begin
          rptr_q <= rptr_q + PW'(1);
          dout_q <= mem_q[rptr_q[AW-1:0]];
        end
        valid_q <= pop_ch[gi];
        empty_q <= (cnt_d == '0);
        full_q  <= (cnt_d == PW'(DEPTH));
        // Edge-triggered sets take priority over a same-cycle clear.
        if ((cnt_d == PW'(DEPTH)) && !full_now[gi]) irq_f_q <= 1'b1;
        else if (irq_clear_full[gi])                irq_f_q <= 1'b0;
        if ((cnt_d == '0) && !empty_now[gi])        irq_e_q <= 1'b1;
        else if (irq_clear_empty[gi])               irq_e_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word_d = '0;
    rd_resp_d = RESP_SLVERR;
    for (int c = 0; c < N_CH; c++) begin
      if (ar_idx == IW'(c)) begin
        rd_word_d[31:16] = 16'(cnt[c]);
        rd_word_d[3:0]   = {irq_empty[c], irq_full[c], rd_full[c], rd_empty[c]};
        rd_resp_d        = RESP_OKAY;
      end
`ifdef AXI_PEEK_EN
      if ((ar_idx == IW'(N_CH + c)) && !empty_now[c]) begin
        rd_word_d = head[c];
        rd_resp_d = RESP_OKAY;
      end
`endif
    end
  end

  always_ff @(posedge clk_axi or posedge axi_reset) begin
    if (axi_reset) begin
      ready_en_q  <= 1'b0;
      aw_held_q   <= 1'b0;
      aw_idx_q    <= '0;
      w_held_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_ok_q <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (awvalid && awready) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= awaddr[ADDR_WIDTH-1:2];
      end
      if (wvalid && wready) begin
        w_held_q    <= 1'b1;
        w_data_q    <= wdata;
        w_strb_ok_q <= &wstrb;
      end
      if (push_fire) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= push_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && bready) begin
        bvalid_q <= 1'b0;
      end
      if (arvalid && arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word_d;
        rresp_q  <= rd_resp_d;
      end else if (rvalid_q && rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end
endmodule
